// File: rtl/fib_bcd_pkg.sv
// fib_bcd_pkg: FSM state type, BCD width helper and digit-count limits for fib_bcd_gen
package fib_bcd_pkg;

    typedef enum logic [2:0] {S_IDLE, S_CONV_IN, S_FIB, S_CONV_OUT, S_DONE} t_fib_state;

    localparam int IN_DIGITS_MIN  = 1;
    localparam int IN_DIGITS_MAX  = 3;
    localparam int OUT_DIGITS_MIN = 1;
    localparam int OUT_DIGITS_MAX = 9;

    function automatic int bcd_bin_w(input int d);
        return $clog2(10 ** d);
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: serial double-dabble, one bit per cycle, W cycles after start
module bin2bcd_seq
    import fib_bcd_pkg::*;
#(
    parameter int W      = 14,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  start,
    input  logic                  clr,
    input  logic [W-1:0]          bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]        sr;
    logic [4*DIGITS-1:0] dig;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       left;

    always_comb begin
        adj = dig;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = dig[4*i +: 4] >= 4'd5 ? dig[4*i +: 4] + 4'd3 : dig[4*i +: 4];
    end

    // bcd is the digit vector after the current step, so it is final while done is high
    assign bcd  = (adj << 1) | (4*DIGITS)'(sr[W-1]);
    assign done = left == CW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr   <= '0;
            dig  <= '0;
            left <= '0;
        end else if (clr) begin
            left <= '0;
        end else if (start) begin
            sr   <= bin;
            dig  <= '0;
            left <= CW'(W);
        end else if (left != '0) begin
            sr   <= sr << 1;
            dig  <= bcd;
            left <= left - CW'(1);
        end
    end

endmodule

// File: rtl/fib_bcd_gen.sv
// fib_bcd_gen: BCD index in, saturated BCD Fibonacci out; FIB_BCD_CHECK_EN adds illegal-nibble rejection
module fib_bcd_gen
    import fib_bcd_pkg::*;
#(
    parameter int IN_DIGITS  = 2,
    parameter int OUT_DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [4*IN_DIGITS-1:0]  i_amt_bcd,
    output logic                    o_ready,
    output logic                    o_done,
    output logic                    o_ovf,
    output logic                    o_err,
    output logic [4*OUT_DIGITS-1:0] o_result_bcd
);

    localparam int IN_W  = bcd_bin_w(IN_DIGITS);
    localparam int OUT_W = bcd_bin_w(OUT_DIGITS);
    localparam int AMT_W = 4 * IN_DIGITS;
    localparam int DC_W  = $clog2(IN_DIGITS + 1);
    localparam logic [OUT_W:0] MAX = (OUT_W + 1)'(10 ** OUT_DIGITS - 1);

    if (IN_DIGITS < IN_DIGITS_MIN || IN_DIGITS > IN_DIGITS_MAX ||
        OUT_DIGITS < OUT_DIGITS_MIN || OUT_DIGITS > OUT_DIGITS_MAX) begin : g_bad_param
        $error("fib_bcd_gen: digit parameters out of range");
    end

    t_fib_state               state, state_nx;
    logic [AMT_W-1:0]         amt_q;
    logic [IN_W-1:0]          cnt;
    logic [DC_W-1:0]          dcnt;
    logic [OUT_W-1:0]         a;
    logic [OUT_W:0]           b;
    logic                     ovf_q;
    logic                     accept, bad, fib_end, bcd_start, bcd_done, to_done;
    logic [OUT_W-1:0]         fib_val;
    logic [4*OUT_DIGITS-1:0]  bcd;

    assign accept    = state == S_IDLE && i_start;
    assign fib_end   = state == S_FIB && (cnt == '0 || b > MAX);
    assign fib_val   = cnt == '0 ? a : MAX[OUT_W-1:0];
    assign bcd_start = fib_end && !i_abort;
    assign to_done   = state == S_CONV_OUT && bcd_done && !i_abort;
    assign o_ready   = state == S_IDLE;
    assign o_done    = state == S_DONE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:     state_nx = accept ? (bad ? S_DONE : S_CONV_IN) : S_IDLE;
            S_CONV_IN:  state_nx = i_abort ? S_IDLE : dcnt == DC_W'(IN_DIGITS - 1) ? S_FIB : S_CONV_IN;
            S_FIB:      state_nx = i_abort ? S_IDLE : fib_end ? S_CONV_OUT : S_FIB;
            S_CONV_OUT: state_nx = i_abort ? S_IDLE : bcd_done ? S_DONE : S_CONV_OUT;
            default:    state_nx = S_IDLE;
        endcase
    end

    // cnt doubles as the BCD-to-binary accumulator and then the Fibonacci step counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            amt_q        <= '0;
            cnt          <= '0;
            dcnt         <= '0;
            a            <= '0;
            b            <= '0;
            ovf_q        <= 1'b0;
            o_ovf        <= 1'b0;
            o_result_bcd <= '0;
        end else begin
            if (accept) begin
                amt_q <= i_amt_bcd;
                cnt   <= '0;
                dcnt  <= '0;
                a     <= '0;
                b     <= (OUT_W + 1)'(1);
            end
            if (state == S_CONV_IN) begin
                amt_q <= amt_q << 4;
                cnt   <= cnt * IN_W'(10) + IN_W'(amt_q[AMT_W-1 -: 4]);
                dcnt  <= dcnt + DC_W'(1);
            end
            if (state == S_FIB) begin
                if (fib_end) begin
                    ovf_q <= cnt != '0;
                end else begin
                    a   <= b[OUT_W-1:0];
                    b   <= {1'b0, a} + b;
                    cnt <= cnt - IN_W'(1);
                end
            end
            if (to_done) begin
                o_result_bcd <= bcd;
                o_ovf        <= ovf_q;
            end else if (accept && bad) begin
                o_result_bcd <= '0;
                o_ovf        <= 1'b0;
            end
        end
    end

    bin2bcd_seq #(.W(OUT_W), .DIGITS(OUT_DIGITS)) u_b2b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (bcd_start),
        .clr     (i_abort),
        .bin     (fib_val),
        .done    (bcd_done),
        .bcd     (bcd)
    );

`ifdef FIB_BCD_CHECK_EN
    logic err_q;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < IN_DIGITS; i++)
            bad = bad | (i_amt_bcd[4*i +: 4] > 4'd9);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)            err_q <= 1'b0;
        else if (accept && bad)  err_q <= 1'b1;
        else if (to_done)        err_q <= 1'b0;
    end

    assign o_err = err_q;
`else
    assign bad   = 1'b0;
    assign o_err = 1'b0;
`endif

endmodule
